wb_commit_unit: RTL and testbench

- Writeback stage directly upstream of the integer register file.
- Accepts results from two producers via valid/ready:
  - ALU path: single-cycle results.
  - LSU path: load and multi-cycle results.
- Arbitrates between the two and drives the register file write port (wen/waddr/wdata) one cycle after acceptance.
- Keeps a pending-write scoreboard so decode can stall on RAW hazards, and counts retired results.

---
 rtl/wb_commit_unit_if.sv | 40 ++++
 rtl/wb_commit_unit.sv | 97 +++++++++
 tb/tb_wb_commit_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_unit_if.sv
// Writeback bundle: ALU/LSU result offers, decode issue, register-file write port and scoreboard.
// Latency and backpressure are set by the unit on the slave side; the interface itself is pure wiring.
interface wb_commit_unit_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
);
    logic                       alu_valid;
    logic                       alu_ready;
    logic [ADDR_WIDTH-1:0]      alu_rd;
    logic [DATA_WIDTH-1:0]      alu_data;
    logic                       lsu_valid;
    logic                       lsu_ready;
    logic [ADDR_WIDTH-1:0]      lsu_rd;
    logic [DATA_WIDTH-1:0]      lsu_data;
    logic                       issue_set;
    logic [ADDR_WIDTH-1:0]      issue_rd;
    logic                       wen;
    logic [ADDR_WIDTH-1:0]      waddr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [2**ADDR_WIDTH-1:0]   pend;
    logic                       retire;
    logic [CNT_WIDTH-1:0]       retire_cnt;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_set, issue_rd,
        input  alu_ready, lsu_ready,
        input  wen, waddr, wdata, pend, retire, retire_cnt
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_set, issue_rd,
        output alu_ready, lsu_ready,
        output wen, waddr, wdata, pend, retire, retire_cnt
    );
endinterface

// File: rtl/wb_commit_unit.sv
// Writeback commit: arbitrates ALU/LSU results, writes the register file 1 cycle after acceptance.
// Never back-pressures for capacity; only the loser of LSU-priority arbitration (with ALU anti-starvation) sees ready low.
module wb_commit_unit #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_commit_unit_if.slave bus
);
    localparam int NREG = 2**ADDR_WIDTH;
    localparam int SW   = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0]          starve_cnt;
    logic                   starve_hit;
    logic                   alu_hs;
    logic                   lsu_hs;
    logic                   acc;
    logic [ADDR_WIDTH-1:0]  sel_rd;
    logic [DATA_WIDTH-1:0]  sel_data;

    logic                   wen_q;
    logic [ADDR_WIDTH-1:0]  waddr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   retire_q;
    logic [CNT_WIDTH-1:0]   retire_cnt_q;
    logic [NREG-1:0]        pend_q;
    logic [NREG-1:0]        pend_nxt;

    assign starve_hit    = (starve_cnt >= SW'(STARVE_LIMIT));
    assign bus.lsu_ready = rst_n && !(bus.alu_valid && starve_hit);
    assign bus.alu_ready = rst_n && (!bus.lsu_valid || starve_hit);

    assign alu_hs   = bus.alu_valid && bus.alu_ready;
    assign lsu_hs   = bus.lsu_valid && bus.lsu_ready;
    assign acc      = alu_hs || lsu_hs;
    assign sel_rd   = alu_hs ? bus.alu_rd   : bus.lsu_rd;
    assign sel_data = alu_hs ? bus.alu_data : bus.lsu_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!bus.alu_valid || alu_hs) begin
            starve_cnt <= '0;
        end else if (!starve_hit) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Single commit register; x0 results retire but never assert the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            retire_q     <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            wen_q        <= acc && (sel_rd != '0);
            retire_q     <= acc;
            retire_cnt_q <= retire_cnt_q + CNT_WIDTH'(retire_q);
            if (acc) begin
                waddr_q <= sel_rd;
                wdata_q <= sel_data;
            end
        end
    end

    // Set is applied after clear so a fresh issue to the same register stays pending.
    always_comb begin
        pend_nxt = pend_q;
        if (wen_q) begin
            pend_nxt[waddr_q] = 1'b0;
        end
        if (bus.issue_set && (bus.issue_rd != '0)) begin
            pend_nxt[bus.issue_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt;
        end
    end

    assign bus.wen        = wen_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.retire     = retire_q;
    assign bus.retire_cnt = retire_cnt_q;
    assign bus.pend       = pend_q;
endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: expected commits queued at drive time, popped on retire.
// Retire counter is built 4 bits wide so the wrap case is reachable quickly.
module tb_wb_commit_unit;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int SL = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_commit_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    wb_commit_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .CNT_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Commit monitor: every retire must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.retire === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_retire", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("waddr", bus.waddr, mon_e.rd);
                    chk("wdata", bus.wdata, mon_e.data);
                    chk("wen",   bus.wen,   (mon_e.rd != '0));
                end
            end else if (bus.wen !== 1'b0) begin
                chk("wen_wo_retire", bus.wen, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_alu(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_data  = data;
        exp_q.push_back('{rd: rd, data: data});
        @(negedge clk);
        chk("alu_rdy", bus.alu_ready, 1);
        tick();
        bus.alu_valid = 1'b0;
    endtask

    task automatic send_lsu(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = rd;
        bus.lsu_data  = data;
        exp_q.push_back('{rd: rd, data: data});
        @(negedge clk);
        chk("lsu_rdy", bus.lsu_ready, 1);
        tick();
        bus.lsu_valid = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        bus.issue_set = 1'b1;
        bus.issue_rd  = rd;
        tick();
        bus.issue_set = 1'b0;
    endtask

    // ALU commit with a decode issue landing on the same edge as the register-file write.
    task automatic commit_with_issue(input logic [AW-1:0] rd, input logic [DW-1:0] data,
                                     input logic [AW-1:0] irq_rd);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_data  = data;
        exp_q.push_back('{rd: rd, data: data});
        tick();
        bus.alu_valid = 1'b0;
        bus.issue_set = 1'b1;
        bus.issue_rd  = irq_rd;
        tick();
        bus.issue_set = 1'b0;
    endtask

    logic [5:0] lsu_win;

    initial begin
        rst_n         = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = '0;
        bus.lsu_data  = '0;
        bus.issue_set = 1'b0;
        bus.issue_rd  = '0;
        lsu_win       = 6'b101111;

        repeat (3) @(negedge clk);
        chk("rst_alu_rdy", bus.alu_ready, 0);
        chk("rst_lsu_rdy", bus.lsu_ready, 0);
        chk("rst_wen",     bus.wen, 0);
        chk("rst_retire",  bus.retire, 0);
        chk("rst_waddr",   bus.waddr, 0);
        chk("rst_wdata",   bus.wdata, 0);
        chk("rst_cnt",     bus.retire_cnt, 0);
        chk("rst_pend",    bus.pend, 0);
        rst_n = 1'b1;
        tick();

        // Single ALU result clearing a pending bit
        issue(5);
        chk("pend5_set", bus.pend, 64'h20);
        send_alu(5, 64'h1234);
        idle(3);
        chk("pend5_clr", bus.pend, 0);
        chk("cnt_single", bus.retire_cnt, 1);

        issue(0);
        chk("issue_x0", bus.pend, 0);
        issue(12);
        chk("pend12_set", bus.pend, 64'h1000);

        // Contention: LSU wins four times, starved ALU wins once, LSU again
        for (int i = 0; i < 6; i++) begin
            if (lsu_win[i]) exp_q.push_back('{rd: 5'd7, data: 64'h700 + 64'((i < 5) ? i : 4)});
            else            exp_q.push_back('{rd: 5'd8, data: 64'h800});
        end
        for (int i = 0; i < 6; i++) begin
            bus.lsu_valid = 1'b1;
            bus.lsu_rd    = 5'd7;
            bus.lsu_data  = 64'h700 + 64'((i < 5) ? i : 4);
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'd8;
            bus.alu_data  = (i < 5) ? 64'h800 : 64'h801;
            @(negedge clk);
            chk($sformatf("cont_lsu_rdy%0d", i), bus.lsu_ready, lsu_win[i]);
            chk($sformatf("cont_alu_rdy%0d", i), bus.alu_ready, !lsu_win[i]);
            tick();
        end
        bus.lsu_valid = 1'b0;
        bus.alu_valid = 1'b0;
        idle(3);
        chk("cnt_cont", bus.retire_cnt, 7);
        chk("sb_empty_cont", exp_q.size(), 0);

        // x0 write retires without a register write
        send_lsu(0, 64'hFFFF);
        idle(3);
        chk("cnt_x0", bus.retire_cnt, 8);
        chk("pend_x0", bus.pend, 64'h1000);

        // Scoreboard race: same-index set beats clear
        issue(9);
        chk("pend9_set", bus.pend, 64'h1200);
        commit_with_issue(9, 64'h99, 9);
        chk("pend9_race", bus.pend, 64'h1200);
        send_alu(9, 64'h9A);
        idle(3);
        chk("pend9_clr", bus.pend, 64'h1000);

        // Different indices on the same edge: both apply
        commit_with_issue(12, 64'hC, 13);
        idle(2);
        chk("pend_diff", bus.pend, 64'h2000);
        chk("cnt_race", bus.retire_cnt, 11);
        chk("sb_empty_race", exp_q.size(), 0);

        // Reset mid-stream discards the offered result
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 64'h55;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_rdy", bus.alu_ready, 0);
        chk("mid_rst_lsu_rdy", bus.lsu_ready, 0);
        bus.alu_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_wen", bus.wen, 0);
        chk("mid_rst_cnt", bus.retire_cnt, 0);
        chk("mid_rst_pend", bus.pend, 0);
        idle(2);
        chk("mid_rst_retire", bus.retire, 0);

        // Counter wrap: 17 back-to-back ALU commits on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(20 + (i % 8));
            bus.alu_data  = {$urandom, $urandom};
            exp_q.push_back('{rd: bus.alu_rd, data: bus.alu_data});
            tick();
        end
        bus.alu_valid = 1'b0;
        idle(3);
        chk("cnt_wrap", bus.retire_cnt, 1);
        chk("sb_empty_wrap", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
